// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32I sequencer (PC, IR, FSM, ALU controls, shared memory port arbitration)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_req/we/addr/funct3     single memory port, shared by fetch (word at pc) and load/store
//   mem_wdata                  store data (ALU result, alu_op 4 passes rs2)
//   mem_ready, mem_rdata       request completes when mem_ready is sampled high with mem_req
//   pc                         current program counter
//   alu_op, addr_alu_op        operation selects for the shared ALU and address ALU
//   funct3, imm                IR[14:12] and the decoded immediate
//   alu_out, addr_alu_out      ALU results fed back for next-PC, memory address and write data
//   cmp_out, alu_fault         branch compare result, ALU illegal-funct7 flag
//   rs1_idx, rs2_idx, rd_idx   register indices from IR
//   rf_we, wb_sel, rf_wdata    register write strobe, source select and the selected write data
//   trap, trap_cause           sticky halt flag and its cause code
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [2:0]  alu_op,
    output logic [1:0]  addr_alu_op,
    output logic [2:0]  funct3,
    output logic [31:0] imm,
    input  logic [31:0] alu_out,
    input  logic [31:0] addr_alu_out,
    input  logic        cmp_out,
    input  logic        alu_fault,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [4:0]  rd_idx,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] rf_wdata,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ld_q, ld_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;

    logic [6:0]  opc;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
    logic        is_store, is_opimm, is_op, is_fence, is_system;
    logic        known, writes_rd, alu_flt, misaligned;
    logic [31:0] pc_plus4, next_pc;

    assign opc       = ir_q[6:0];
    assign is_lui    = opc == OPC_LUI;
    assign is_auipc  = opc == OPC_AUIPC;
    assign is_jal    = opc == OPC_JAL;
    assign is_jalr   = opc == OPC_JALR;
    assign is_branch = opc == OPC_BRANCH;
    assign is_load   = opc == OPC_LOAD;
    assign is_store  = opc == OPC_STORE;
    assign is_opimm  = opc == OPC_OPIMM;
    assign is_op     = opc == OPC_OP;
    assign is_fence  = opc == OPC_FENCE;
    assign is_system = opc == OPC_SYSTEM;

    assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                   is_store | is_opimm | is_op | is_fence | is_system;
    assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_opimm | is_op;

    assign funct3  = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign rd_idx  = ir_q[11:7];
    assign pc      = pc_q;
    assign trap    = trap_q;
    assign trap_cause = cause_q;

    // ALU controls depend only on IR so they stay valid through EXEC and MEM.
    assign alu_op = (is_jal | is_jalr) ? 3'd1 :
                    is_opimm           ? 3'd5 :
                    is_op              ? 3'd6 :
                    is_store           ? 3'd4 : 3'd0;
    assign addr_alu_op = (is_auipc | is_jal | is_branch)  ? 2'd1 :
                         (is_jalr | is_load | is_store)   ? 2'd2 : 2'd0;
    assign wb_sel = is_load ? 2'd2 : is_auipc ? 2'd1 : 2'd0;
    assign rf_wdata = is_load ? ld_q : is_auipc ? addr_alu_out : alu_out;
    assign mem_wdata = alu_out;

    // OP shares the I-type immediate so imm[11:5] carries funct7 to the ALU.
    always_comb begin
        imm = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opc)
            OPC_STORE:          imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OPC_BRANCH:         imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {ir_q[31:12], 12'd0};
            OPC_JAL:            imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:            ;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = (is_jal | (is_branch & cmp_out)) ? addr_alu_out :
                      is_jalr ? (addr_alu_out & ~32'd1) : pc_plus4;
    assign alu_flt    = alu_fault & (is_op | is_opimm);
    assign misaligned = next_pc[1:0] != 2'b00;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ld_d       = ld_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        rf_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_q;
        mem_funct3 = 3'b010;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!known || is_system) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = is_system ? 2'd3 : 2'd0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (alu_flt || misaligned) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = alu_flt ? 2'd1 : 2'd2;
                end else begin
                    rf_we   = writes_rd && (rd_idx != 5'd0);
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = is_store;
                mem_addr   = addr_alu_out;
                mem_funct3 = ir_q[14:12];
                if (mem_ready) begin
                    ld_d    = is_store ? ld_q : mem_rdata;
                    pc_d    = is_store ? pc_plus4 : pc_q;
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we   = rd_idx != 5'd0;
                pc_d    = pc_plus4;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0013;
            ld_q    <= 32'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ld_q    <= ld_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: table-driven and directed checks of the core_seq_ctrl sequencer
module tb_core_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, imm, alu_out, addr_alu_out, rf_wdata;
    logic [2:0]  mem_funct3, alu_op, funct3;
    logic [1:0]  addr_alu_op, wb_sel, trap_cause;
    logic        cmp_out, alu_fault, rf_we, trap;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;

    always #5 clk = ~clk;

    core_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc(pc), .alu_op(alu_op), .addr_alu_op(addr_alu_op), .funct3(funct3), .imm(imm),
        .alu_out(alu_out), .addr_alu_out(addr_alu_out), .cmp_out(cmp_out), .alu_fault(alu_fault),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx), .rf_we(rf_we), .wb_sel(wb_sel),
        .rf_wdata(rf_wdata), .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct {
        logic [31:0] instr, aao;
        logic        cmp, flt;
        int          hs;
        logic [31:0] pc;
        int          cyc, we;
        logic        trp;
        logic [1:0]  cause;
        logic [2:0]  alu;
        logic [1:0]  aop, wb;
        logic [4:0]  rd;
        logic [31:0] imm, wd;
        logic        mwe;
    } vec_t;

    localparam logic [31:0] LDW = 32'hDEAD_BEEF;
    localparam logic [31:0] ALUV = 32'h0000_0055;

    vec_t v [18];
    int n_cmp = 0;
    int n_bad = 0;
    int r_pc_cyc, r_we_cnt, r_fetch_bad, r_trap_req;
    logic [4:0]  r_we_rd;
    logic [31:0] r_we_data, r_maddr, r_mwd;
    logic        r_mwe;
    logic [2:0]  r_mf3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one instruction: optional reset, then 12 cycles with a memory that
    // answers the first hs_lim requests after wait_n wait cycles each.
    task automatic run(input string tag, input logic [31:0] instr, input logic [31:0] aao,
                       input logic cmp, input logic flt, input int hs_lim, input int wait_n,
                       input bit rst, input logic [31:0] fpc, input logic [4:0] rd0);
        int hs, age;
        logic [31:0] prev;
        hs = 0; age = 0;
        r_pc_cyc = -1; r_we_cnt = 0; r_fetch_bad = 0; r_trap_req = 0;
        r_we_rd = 5'd0; r_we_data = 32'd0; r_maddr = 32'd0; r_mwe = 1'b0; r_mwd = 32'd0; r_mf3 = 3'd0;
        addr_alu_out = aao; cmp_out = cmp; alu_fault = flt; mem_ready = 1'b0; mem_rdata = instr;
        if (rst) begin
            rst_n = 1'b0;
            #1;
            chk($sformatf("%s rst pc", tag), pc, 32'h0);
            chk($sformatf("%s rst trap", tag), {31'd0, trap}, 32'd0);
            chk($sformatf("%s rst cause", tag), {30'd0, trap_cause}, 32'd0);
            chk($sformatf("%s rst strobes", tag), {29'd0, mem_req, mem_we, rf_we}, 32'd0);
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
        for (int c = 0; c < 12; c++) begin
            mem_ready = mem_req && (hs < hs_lim) && (age >= wait_n);
            mem_rdata = (hs == 0) ? instr : LDW;
            if (mem_req && hs == 0 && (mem_addr !== fpc || mem_we !== 1'b0 ||
                mem_funct3 !== 3'b010 || rd_idx !== rd0)) r_fetch_bad++;
            if (rst && c == 0 && mem_req !== 1'b0) r_fetch_bad++;
            if (rst && c == 1 && mem_req !== 1'b1) r_fetch_bad++;
            if (mem_req && hs == 1) begin
                r_maddr = mem_addr; r_mwe = mem_we; r_mwd = mem_wdata; r_mf3 = mem_funct3;
            end
            if (rf_we) begin
                r_we_cnt++; r_we_rd = rd_idx; r_we_data = rf_wdata;
            end
            if (trap && mem_req) r_trap_req++;
            prev = pc;
            if (mem_req && mem_ready) begin
                hs++; age = 0;
            end else if (mem_req) begin
                age++;
            end
            @(posedge clk);
            #1;
            if (pc !== prev && r_pc_cyc < 0) r_pc_cyc = c;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        alu_out = ALUV; addr_alu_out = 32'd0; cmp_out = 1'b0; alu_fault = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        //          instr         aao           cmp   flt   hs pc            cyc we trp   cause alu   aop   wb    rd     imm           wd     mwe
        v[0]  = '{32'h00500093, 32'h0,       1'b0, 1'b0, 1, 32'h4,       3,  1, 1'b0, 2'd0, 3'd5, 2'd0, 2'd0, 5'd1,  32'h5,        ALUV,  1'b0};
        v[1]  = '{32'h00802103, 32'h8,       1'b0, 1'b0, 2, 32'h4,       5,  1, 1'b0, 2'd0, 3'd0, 2'd2, 2'd2, 5'd2,  32'h8,        LDW,   1'b0};
        v[2]  = '{32'h00302623, 32'hC,       1'b0, 1'b0, 2, 32'h4,       4,  0, 1'b0, 2'd0, 3'd4, 2'd2, 2'd0, 5'd12, 32'hC,        32'h0, 1'b1};
        v[3]  = '{32'h04000063, 32'h40,      1'b1, 1'b0, 1, 32'h40,      3,  0, 1'b0, 2'd0, 3'd0, 2'd1, 2'd0, 5'd0,  32'h40,       32'h0, 1'b0};
        v[4]  = '{32'h04000063, 32'h40,      1'b0, 1'b0, 1, 32'h4,       3,  0, 1'b0, 2'd0, 3'd0, 2'd1, 2'd0, 5'd0,  32'h40,       32'h0, 1'b0};
        v[5]  = '{32'h002082B3, 32'h0,       1'b0, 1'b1, 1, 32'h0,       -1, 0, 1'b1, 2'd1, 3'd6, 2'd0, 2'd0, 5'd5,  32'h2,        32'h0, 1'b0};
        v[6]  = '{32'h002082B3, 32'h0,       1'b0, 1'b0, 1, 32'h4,       3,  1, 1'b0, 2'd0, 3'd6, 2'd0, 2'd0, 5'd5,  32'h2,        ALUV,  1'b0};
        v[7]  = '{32'h0000007F, 32'h0,       1'b0, 1'b0, 1, 32'h0,       -1, 0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 5'd0,  32'h0,        32'h0, 1'b0};
        v[8]  = '{32'h002000EF, 32'h2,       1'b0, 1'b0, 1, 32'h0,       -1, 0, 1'b1, 2'd2, 3'd1, 2'd1, 2'd0, 5'd1,  32'h2,        32'h0, 1'b0};
        v[9]  = '{32'h002000EF, 32'h100,     1'b0, 1'b0, 1, 32'h100,     3,  1, 1'b0, 2'd0, 3'd1, 2'd1, 2'd0, 5'd1,  32'h2,        ALUV,  1'b0};
        v[10] = '{32'h000280E7, 32'h201,     1'b0, 1'b0, 1, 32'h200,     3,  1, 1'b0, 2'd0, 3'd1, 2'd2, 2'd0, 5'd1,  32'h0,        ALUV,  1'b0};
        v[11] = '{32'h00000073, 32'h0,       1'b0, 1'b0, 1, 32'h0,       -1, 0, 1'b1, 2'd3, 3'd0, 2'd0, 2'd0, 5'd0,  32'h0,        32'h0, 1'b0};
        v[12] = '{32'h123453B7, 32'h0,       1'b0, 1'b0, 1, 32'h4,       3,  1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 5'd7,  32'h12345000, ALUV,  1'b0};
        v[13] = '{32'h00001017, 32'h1000,    1'b0, 1'b0, 1, 32'h4,       3,  0, 1'b0, 2'd0, 3'd0, 2'd1, 2'd1, 5'd0,  32'h1000,     32'h0, 1'b0};
        v[14] = '{32'h0000000F, 32'h0,       1'b0, 1'b0, 1, 32'h4,       3,  0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 5'd0,  32'h0,        32'h0, 1'b0};
        v[15] = '{32'h04000063, 32'h42,      1'b1, 1'b0, 1, 32'h0,       -1, 0, 1'b1, 2'd2, 3'd0, 2'd1, 2'd0, 5'd0,  32'h40,       32'h0, 1'b0};
        v[16] = '{32'h123453B7, 32'h0,       1'b0, 1'b1, 1, 32'h4,       3,  1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 5'd7,  32'h12345000, ALUV,  1'b0};
        v[17] = '{32'hFFF00093, 32'h0,       1'b0, 1'b0, 1, 32'h4,       3,  1, 1'b0, 2'd0, 3'd5, 2'd0, 2'd0, 5'd1,  32'hFFFFFFFF, ALUV,  1'b0};
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            run(t, v[i].instr, v[i].aao, v[i].cmp, v[i].flt, v[i].hs, 0, 1'b1, 32'h0, 5'd0);
            chk({t, " pc"}, pc, v[i].pc);
            chk({t, " pc_cycle"}, 32'(r_pc_cyc), 32'(v[i].cyc));
            chk({t, " rf_we_count"}, 32'(r_we_cnt), 32'(v[i].we));
            chk({t, " trap"}, {31'd0, trap}, {31'd0, v[i].trp});
            chk({t, " trap_cause"}, {30'd0, trap_cause}, {30'd0, v[i].cause});
            chk({t, " alu_op"}, {29'd0, alu_op}, {29'd0, v[i].alu});
            chk({t, " addr_alu_op"}, {30'd0, addr_alu_op}, {30'd0, v[i].aop});
            chk({t, " wb_sel"}, {30'd0, wb_sel}, {30'd0, v[i].wb});
            chk({t, " rd_idx"}, {27'd0, rd_idx}, {27'd0, v[i].rd});
            chk({t, " rs1_idx"}, {27'd0, rs1_idx}, {27'd0, v[i].instr[19:15]});
            chk({t, " rs2_idx"}, {27'd0, rs2_idx}, {27'd0, v[i].instr[24:20]});
            chk({t, " funct3"}, {29'd0, funct3}, {29'd0, v[i].instr[14:12]});
            chk({t, " imm"}, imm, v[i].imm);
            chk({t, " fetch_bad"}, 32'(r_fetch_bad), 32'd0);
            chk({t, " req_in_trap"}, 32'(r_trap_req), 32'd0);
            if (v[i].we > 0) begin
                chk({t, " we_rd"}, {27'd0, r_we_rd}, {27'd0, v[i].rd});
                chk({t, " we_data"}, r_we_data, v[i].wd);
            end
            if (v[i].hs == 2) begin
                chk({t, " mem_addr"}, r_maddr, v[i].aao);
                chk({t, " mem_we"}, {31'd0, r_mwe}, {31'd0, v[i].mwe});
                chk({t, " mem_funct3"}, {29'd0, r_mf3}, {29'd0, v[i].instr[14:12]});
                if (v[i].mwe) chk({t, " mem_wdata"}, r_mwd, ALUV);
            end
        end
        // fetch with three wait states: address held, IR untouched until mem_ready
        run("wait", 32'h123453B7, 32'h0, 1'b0, 1'b0, 1, 3, 1'b1, 32'h0, 5'd0);
        chk("wait pc_cycle", 32'(r_pc_cyc), 32'd6);
        chk("wait fetch_bad", 32'(r_fetch_bad), 32'd0);
        chk("wait pc", pc, 32'h4);
        chk("wait we_count", 32'(r_we_cnt), 32'd1);
        // pc+4 wraps from the top of the address space without faulting
        run("wrap_jal", 32'h002000EF, 32'hFFFF_FFFC, 1'b0, 1'b0, 1, 0, 1'b1, 32'h0, 5'd0);
        chk("wrap_jal pc", pc, 32'hFFFF_FFFC);
        run("wrap_addi", 32'h00500093, 32'h0, 1'b0, 1'b0, 1, 0, 1'b0, 32'hFFFF_FFFC, 5'd1);
        chk("wrap pc", pc, 32'h0);
        chk("wrap trap", {31'd0, trap}, 32'd0);
        chk("wrap pc_cycle", 32'(r_pc_cyc), 32'd2);
        chk("wrap fetch_bad", 32'(r_fetch_bad), 32'd0);
        // reset while a store is waiting in MEM
        run("pre_jal", 32'h002000EF, 32'h100, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0, 5'd1);
        chk("pre_jal pc", pc, 32'h100);
        run("stuck_sw", 32'h00302623, 32'hC, 1'b0, 1'b0, 1, 0, 1'b0, 32'h100, 5'd1);
        chk("stuck mem_req", {31'd0, mem_req}, 32'd1);
        chk("stuck mem_we", {31'd0, mem_we}, 32'd1);
        chk("stuck mem_addr", mem_addr, 32'hC);
        chk("stuck pc", pc, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst pc", pc, 32'h0);
        chk("midrst trap", {31'd0, trap}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst idle req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst fetch req", {31'd0, mem_req}, 32'd1);
        chk("midrst fetch addr", mem_addr, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle sequencer for the RV32I core: owns the PC and instruction register, runs fetch/decode/execute/memory/writeback, and drives the control inputs of the shared ALU unit (`alu_op`, `addr_alu_op`, `funct3`, `imm`). It also arbitrates the single memory port between instruction fetch and load/store. Faults, illegal opcodes and ECALL/EBREAK put it in a sticky trap state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `clk  in  1`  rising-edge clock.
- `rst_n  in  1`  one clock; reset is asynchronous and active-low.
- `mem_req  out  1`  memory request; held until `mem_ready`.
- `mem_we  out  1`  store when high (valid with `mem_req`).
- `mem_addr  out  32`  `pc` in FETCH, `addr_alu_out` in MEM.
- `mem_funct3  out  3`  access size: 3'b010 in FETCH, IR[14:12] in MEM.
- `mem_ready  in  1`  request completes in the cycle it is sampled high with `mem_req`.
- `mem_rdata  in  32`  read data, valid with `mem_ready`.
- `pc  out  32`  current PC.
- `alu_op  out  3`  ALU operation select.
- `addr_alu_op  out  2`  address ALU select.
- `funct3  out  3`  IR[14:12].
- `imm  out  32`  decoded immediate.
- `alu_out, addr_alu_out  in  32`  ALU results.
- `cmp_out  in  1`  branch compare result.
- `alu_fault  in  1`  ALU illegal-funct7 flag.
- `rs1_idx, rs2_idx, rd_idx  out  5`  IR[19:15], IR[24:20], IR[11:7].
- `rf_we  out  1`  register write strobe; forced low when `rd_idx` is 0.
- `wb_sel  out  2`  write-back source: 0 = `alu_out`, 1 = `addr_alu_out`, 2 = load data.
- `trap  out  1`  sticky halt flag.
- `trap_cause  out  2`  cause code:
  - 0 = illegal opcode
  - 1 = ALU fault
  - 2 = misaligned PC target
  - 3 = ECALL/EBREAK

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **Reset values:**
  - state = IDLE, `pc` = `RESET_PC`, IR = 32'h0000_0013.
  - `trap` = 0, `trap_cause` = 0.
  - All strobes (`mem_req`, `mem_we`, `rf_we`) = 0.
- **IDLE:** goes to FETCH on the next cycle.
- **FETCH:** `mem_req` = 1, `mem_addr` = `pc`. When `mem_ready` is high, latch IR from `mem_rdata` and go to DECODE.
- **DECODE:** one cycle; classify IR[6:0].
  - Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM.
  - Unknown opcode → TRAP, cause 0.
  - SYSTEM → TRAP, cause 3.
  - Otherwise → EXEC.
- **Immediate decode:**
  - I-type, including OP: sign-extended IR[31:20]. `imm[11:5]` therefore carries funct7 for the ALU.
  - S-type, B-type, U-type and J-type: per the RV32I format.
- **EXEC controls, per opcode:**
  - LUI: `alu_op` 0, `wb_sel` 0.
  - AUIPC: `addr_alu_op` 1, `wb_sel` 1.
  - JAL: `alu_op` 1, `wb_sel` 0, next PC = `addr_alu_out` with `addr_alu_op` 1.
  - JALR: `alu_op` 1, `wb_sel` 0, next PC = `addr_alu_out & ~1` with `addr_alu_op` 2.
  - BRANCH: next PC = `addr_alu_out` (`addr_alu_op` 1) if `cmp_out`, else `pc+4`.
  - OP-IMM: `alu_op` 5.
  - OP: `alu_op` 6.
  - LOAD and STORE: `addr_alu_op` 2; STORE also uses `alu_op` 4, so `alu_out` is the write data.
  - FENCE: no operation.
- **EXEC completion:**
  - Non-memory instructions: `rf_we` pulses (except BRANCH, FENCE), `pc` updates, state → FETCH.
  - LOAD and STORE → MEM.
- **EXEC faults:**
  - `alu_fault` high during OP or OP-IMM → TRAP, cause 1. No write-back, PC unchanged.
  - Next-PC bits [1:0] ≠ 0 → TRAP, cause 2. No write-back, PC unchanged.
- **MEM:**
  - `mem_req` = 1, `mem_addr` = `addr_alu_out`, `mem_we` = STORE.
  - `addr_alu_op` and `alu_op` are held.
  - On `mem_ready`: STORE does `pc+4` → FETCH; LOAD latches `mem_rdata` → WB.
- **WB:** `rf_we` = 1, `wb_sel` = 2, `pc+4`, → FETCH.
- **TRAP:** absorbing state, left only by reset. All strobes low; `pc` is frozen at the faulting instruction.
- **Arithmetic:** `pc+4` uses an internal 32-bit adder and wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 0 and is not a fault.

## Timing
- **Latency with zero-wait memory (`mem_ready` high in the first FETCH cycle):**
  - ALU, jump, branch, FENCE: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle on `mem_ready` adds 1 cycle.
- **Handshake:**
  - `mem_req`, `mem_addr`, `mem_we` and `mem_funct3` are stable from assertion until the `mem_ready` cycle.
  - `mem_req` drops in the cycle after `mem_ready`; no back-to-back requests from one state.
  - `mem_ready` is ignored while `mem_req` is low.
- **Write-back timing:**
  - `rf_we` is high for exactly one cycle per retiring instruction.
  - It coincides with the `pc` register update at the end of that cycle.
- **Outputs:** `alu_op`, `addr_alu_op`, `imm`, `funct3` and the register indices are combinational from state and IR. They are valid throughout EXEC and MEM.
- **Reset mid-operation:**
  - `rst_n` low asserts the reset values immediately (asynchronous).
  - An outstanding memory request is abandoned; `mem_req` drops in the same cycle.
  - After release: 1 IDLE cycle, then FETCH from `RESET_PC`.

## Test plan
- **Reset then ADDI:** reset, fetch returns 32'h0050_0093 (addi x1,x0,5) → `mem_req` rises 1 cycle after release, `alu_op`=5, `rf_we` pulses with `rd_idx`=1, `pc`=4 after 3 cycles.
- **Fetch wait states:** `mem_ready` delayed 3 cycles → `mem_addr` held at `pc` throughout, IR latched only on the `mem_ready` cycle, instruction retires at cycle 6.
- **Load:** LW x2,8(x0) with `addr_alu_out`=8 → MEM request with `mem_addr`=8 and `mem_we`=0; WB asserts `rf_we`, `wb_sel`=2, `rd_idx`=2; `pc` advances by 4.
- **Taken branch:** BEQ with `cmp_out`=1, `addr_alu_out`=32'h40 → `pc`=32'h40, no `rf_we`.
- **Not-taken branch:** same BEQ with `cmp_out`=0 → `pc`+4, no `rf_we`.
- **Faults:**
  - OP with `alu_fault`=1 → `trap`=1, `trap_cause`=1, `pc` unchanged, no further `mem_req`.
  - Opcode 7'b1111111 → `trap_cause`=0.
  - JAL with target 32'h2 → `trap_cause`=2.
- **Reset mid-MEM:** `rst_n` low during a pending store → `mem_req` and `mem_we` drop in the same cycle, `pc`=`RESET_PC`, `trap` cleared.
